// File: rtl/score_pkg.sv
// score_pkg: shared types and constants for the score_keeper block.
//   state_t       run-state encoding (IDLE / PLAYING / OVER)
//   BCD_MAX_DIGIT largest value a single BCD digit may hold
package score_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_OVER    = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one 4-bit BCD counter stage of the score chain.
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous active-high reset, clears the digit
//   clear      synchronous clear (start of a new run)
//   inc_in     increment request from the previous stage (or the top level)
//   digit      current BCD digit value
//   carry_out  high when inc_in is high and the digit is at 9 (it wraps to 0)
module bcd_digit
  import score_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc_in,
  output logic [3:0] digit,
  output logic       carry_out
);

  assign carry_out = inc_in && (digit == BCD_MAX_DIGIT);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      digit <= 4'd0;
    end else if (inc_in) begin
      digit <= (digit == BCD_MAX_DIGIT) ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// score_keeper: run-state FSM, BCD pipe counter and session high score.
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous active-high reset
//   start        begin a new run from IDLE or OVER
//   pipe_passed  level; each rising edge in PLAYING adds one to the score
//   collision    level; ends the run when seen in PLAYING
//   score_bcd    current score, digit i in bits [4i+3:4i]
//   high_bcd     session high score, same layout
//   playing      state is PLAYING
//   game_over    state is OVER
//   new_high     in OVER, the last run beat the previous high score
// Build option: define SCORE_KEEPER_HIGH_SCORE_EN to build the high-score
// register and compare; otherwise high_bcd and new_high are tied to 0.
//
// state      | meaning
// ST_IDLE    | after reset, waiting for start
// ST_PLAYING | run in progress, counting pipes
// ST_OVER    | run ended by collision, score held, waiting for start
module score_keeper
  import score_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                pipe_passed,
  input  logic                collision,
  output logic [4*DIGITS-1:0] score_bcd,
  output logic [4*DIGITS-1:0] high_bcd,
  output logic                playing,
  output logic                game_over,
  output logic                new_high
);

  localparam int W = 4 * DIGITS;

  state_t state, state_next;

  logic              pipe_prev;
  logic              inc_event;
  logic              run_start;
  logic              all_nines;
  logic              chain_inc;
  logic [DIGITS:0]   carry;
  logic [DIGITS-1:0] digit_max;
  logic              top_carry_unused;

  // Reset value of 1 keeps a pipe_passed level held through reset from
  // looking like a fresh rising edge.
  always_ff @(posedge clock) begin
    if (reset) pipe_prev <= 1'b1;
    else       pipe_prev <= pipe_passed;
  end

  assign inc_event = pipe_passed && !pipe_prev;

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (start)     state_next = ST_PLAYING;
      ST_PLAYING: if (collision) state_next = ST_OVER;
      ST_OVER:    if (start)     state_next = ST_PLAYING;
      default:                   state_next = ST_IDLE;
    endcase
  end

  assign run_start = start && ((state == ST_IDLE) || (state == ST_OVER));

  // Collision wins over a same-cycle increment; the all-9s gate gives
  // saturation instead of wrapping to zero.
  assign all_nines = &digit_max;
  assign chain_inc = (state == ST_PLAYING) && !collision && inc_event && !all_nines;
  assign carry[0]  = chain_inc;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clock     (clock),
      .reset     (reset),
      .clear     (run_start),
      .inc_in    (carry[g]),
      .digit     (score_bcd[4*g +: 4]),
      .carry_out (carry[g+1])
    );
    assign digit_max[g] = (score_bcd[4*g +: 4] == BCD_MAX_DIGIT);
  end

  // Never set: the chain is gated before the top digit can wrap.
  assign top_carry_unused = carry[DIGITS];

  assign playing   = (state == ST_PLAYING);
  assign game_over = (state == ST_OVER);

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  logic [W-1:0] high_q;
  logic         new_high_q;

  // Packed BCD with the most significant digit on top compares correctly
  // as an unsigned binary number.
  always_ff @(posedge clock) begin
    if (reset) begin
      high_q     <= '0;
      new_high_q <= 1'b0;
    end else if ((state == ST_PLAYING) && collision) begin
      if (score_bcd > high_q) begin
        high_q     <= score_bcd;
        new_high_q <= 1'b1;
      end else begin
        new_high_q <= 1'b0;
      end
    end else if (run_start) begin
      new_high_q <= 1'b0;
    end
  end

  assign high_bcd = high_q;
  assign new_high = new_high_q;
`else
  assign high_bcd = '0;
  assign new_high = 1'b0;
`endif

endmodule

// File: doc/score_keeper.md
# score_keeper

Game score tracker for the flappy-bird design: counts pipes cleared during a run as a multi-digit BCD value, tracks the run state (idle / playing / over) and holds the session high score. Sits directly upstream of the per-digit `hex_display` decoders; each 4-bit slice of `score_bcd` or `high_bcd` drives one HEX digit. Driven by the game-logic pulses `pipe_passed` and `collision` plus a player `start` button.

## Interface
- `DIGITS`, default 2: number of BCD digits in the score and the high score; maximum score is 10^DIGITS − 1.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  level; begins a new run from IDLE or OVER.
- `pipe_passed`  in  1  level from game logic; each rising edge during PLAYING counts one pipe.
- `collision`  in  1  level; any cycle high during PLAYING ends the run.
- `score_bcd`  out  4*DIGITS  current score; digit i in bits [4i+3:4i], digit 0 is least significant.
- `high_bcd`  out  4*DIGITS  session high score, same layout.
- `playing`  out  1  high in state PLAYING.
- `game_over`  out  1  high in state OVER.
- `new_high`  out  1  high in OVER when the last run set a new high score.

## Operation
- Reset: state IDLE; `score_bcd`=0, `high_bcd`=0, `playing`=0, `game_over`=0, `new_high`=0; edge-detect register set to 1, so `pipe_passed` held high through reset never counts.
- Edge detect: `pipe_prev` samples `pipe_passed` every cycle in every state. An increment event is `pipe_passed & ~pipe_prev`.
- IDLE: `start`=1 → PLAYING; score cleared to 0.
- PLAYING:
  - If `collision`=1 → OVER. Collision takes priority: an increment event in the same cycle is dropped.
  - Else on an increment event, the score increments by 1 in BCD. A digit at 9 wraps to 0 and carries into the next digit.
  - The score saturates at all-9s. A further increment leaves it unchanged.
  - `start` is ignored in PLAYING.
- Transition PLAYING→OVER: if `score_bcd` is strictly greater than `high_bcd`, then `high_bcd` ← `score_bcd` and `new_high` ← 1. Otherwise `new_high` ← 0. An equal score does not set `new_high`.
- OVER: `score_bcd` and `high_bcd` are held.
  - `start`=1 → PLAYING; score cleared to 0 and `new_high` cleared to 0.
  - `high_bcd` is retained.
- A `start` pulse held across several cycles causes exactly one transition per state entry. It cannot cause a second restart because `start` is ignored in PLAYING.
- `reset` asserted in any state, including mid-run, restores all reset values at the next edge. The high score is lost.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Increment latency is 1 cycle. With `pipe_passed` sampled 1 at edge N and 0 at edge N−1, `score_bcd` shows +1 after edge N.
- `collision` sampled at edge N: `game_over`, `high_bcd` and `new_high` are updated after edge N, and `playing` is 0.
- `start` sampled at edge N in IDLE or OVER: `playing`=1 and `score_bcd`=0 after edge N.
- An increment event at edge N+1 following a start at edge N is counted.
- Back-to-back increment events need `pipe_passed` low for at least 1 sampled cycle between them.

## Configuration
- `SCORE_KEEPER_HIGH_SCORE_EN` defined: the high-score register, the compare logic and `new_high` are built as described above.
- Not defined: no high-score logic is synthesised. `high_bcd` is tied to 0 and `new_high` to 0. State behaviour and `score_bcd` are unchanged.

## Structure
- Shared package `score_pkg` holds:
  - state encoding constants `ST_IDLE`=2'd0, `ST_PLAYING`=2'd1, `ST_OVER`=2'd2;
  - `BCD_MAX_DIGIT`=4'd9.
- One sub-module, `bcd_digit`: a single 4-bit BCD counter stage with `clear`, `inc_in` and a `carry_out` that is high when `inc_in` is high and the digit is 9.
  - It is instantiated `DIGITS` times in a generate chain.
  - The top level gates the chain's increment when all digits are 9, which implements saturation.

## Test plan
- Reset with `pipe_passed`=1 held, release reset, then hold `pipe_passed` high for 5 cycles → `score_bcd`=0 and state IDLE.
- `start` pulse, then 12 separated `pipe_passed` pulses → `score_bcd`=8'h12 with carry; `playing`=1.
- `collision` with score 8'h12 and `high_bcd`=0 → `game_over`=1, `high_bcd`=8'h12, `new_high`=1. Restart, score 8'h12 again, collide → `new_high`=0 and `high_bcd` stays 8'h12.
- `collision` and a `pipe_passed` rising edge in the same cycle at score 8'h05 → score stays 8'h05, OVER.
- Run 101 pulses with `DIGITS`=2 → `score_bcd` saturates at 8'h99.
- Assert `reset` mid-run at score 8'h07 with `high_bcd`=8'h30 → all outputs 0, state IDLE.
